sdft_stream: RTL and testbench
==============================

SDFT_STREAM -- requirements
Module: sdft_stream

Interface
REQ-001 Parameter data_width, 8, signed input sample width.
REQ-002 Parameter freq_bins, 16, number of bins N (power of two, 4..64).
REQ-003 Parameter coef_width, 12, signed twiddle width; fraction bits = coef_width-2, so 1.0 is exact.
REQ-004 Parameter bin_width, data_width+clog2(freq_bins)+1, signed real/imag bin width.
REQ-005 Port clk  in  1  sole clock, all logic on rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port sample  in  data_width  signed sample, captured with an accepted start.
REQ-008 Port start  in  1  request to process sample.
REQ-009 Port clear  in  1  zero sample history, bins and overflow without reset.
REQ-010 Port ready  out  1  high when IDLE and able to accept start or clear.
REQ-011 Port bin_addr  in  clog2(freq_bins)  bin read index.
REQ-012 Port bin_real, bin_imag  out  bin_width each  registered read data for bin_addr.
REQ-013 Port overflow  out  1  sticky, set when any bin update saturated.

Function
REQ-014 Update rule per bin k: X_k <= sat((X_k + d) * W_k), d = x_new - x_oldest (data_width+1 bits), W_k = cos(2πk/N) + j·sin(2πk/N) from twiddle ROM.
REQ-015 Complex product: 4 full-width multiplies, sums at full precision, arithmetic shift right by coef_width-2 (floor), then saturate to bin_width.
REQ-016 Saturation clamps to +(2^(bin_width-1)-1) / -2^(bin_width-1) independently per real/imag, sets overflow.
REQ-017 FSM states IDLE, DELTA, BINS, COMMIT.
REQ-018 IDLE: ready=1; start=1 captures sample, goes to DELTA; clear=1 takes priority over start, zeroes all state in that cycle, stays IDLE, start ignored.
REQ-019 DELTA: read oldest sample at write pointer, register d, k<=0, go to BINS.
REQ-020 BINS: update bin k, one bin per cycle; after k=N-1 go to COMMIT.
REQ-021 COMMIT: write captured sample at pointer, pointer increments modulo N (wraps N-1 -> 0), go to IDLE.
REQ-022 ready falls the cycle after start acceptance; busy lasts exactly N+2 cycles (18 for N=16); a new start may be accepted the cycle ready returns.
REQ-023 start and clear while not IDLE are ignored, not queued; sample changes while busy have no effect.
REQ-024 Read port: bin_real/bin_imag = bin[bin_addr] one cycle after bin_addr, any state; coherent (single snapshot) only while ready=1.
REQ-025 overflow stays set until reset or clear.

Reset
REQ-026 reset overrides everything in any state, including mid-BINS: next cycle FSM=IDLE, ready=1, pointer=0, all samples and bins 0, bin_real=bin_imag=0, overflow=0.
REQ-027 First sample after reset sees x_oldest=0.

Structure
REQ-028 Shared package sdft_pkg holds state encoding, Q-format constants and the twiddle-value generation function.
REQ-029 One sub-module sdft_twiddle_rom (index in, cos/sin coef_width out, combinational) instantiated once.
REQ-030 Sample history and bins are register arrays with one write per cycle; no extra multipliers beyond REQ-015.

Verification
REQ-031 Defaults, 16 starts with sample=+100 after reset -> X_0 real=1600 imag=0; |X_k| ≤ 16 for k≠0; overflow=0.
REQ-032 Defaults, two periods of 8×(-100) then 8×(+100) -> X_0 = 0 ±2, |X_1| = 1025 ±2%, even k≠0 |X_k| ≤ 16.
REQ-033 start held high continuously -> one acceptance per 19 cycles, ready low exactly 18 cycles each; 20th sample overwrites history slot 3 (wrap).
REQ-034 bin_width=10, 16 starts with sample=127 -> X_0 real=511 (clamped), overflow=1; then clear -> all bins 0, overflow=0, ready stays 1.
REQ-035 reset asserted at k=5 of BINS -> next cycle ready=1, every bin reads 0, overflow=0; subsequent sample=+100 -> X_0=100.
REQ-036 start and clear together in IDLE -> state cleared, no processing, ready never drops.

Source files
------------

// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT stream engine: FSM encoding,
// twiddle Q-format and the elaboration-time twiddle generator.
package sdft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELTA  = 2'd1,
    ST_BINS   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Sign bit plus one integer bit, so a twiddle of exactly 1.0 is representable.
  localparam int COEF_GUARD   = 2;
  localparam int TAYLOR_TERMS = 12;
  localparam real TWO_PI      = 6.283185307179586;

  // cos/sin(2*pi*k/n) scaled by 2^frac and rounded to nearest; only ever
  // evaluated with constant arguments to fill the twiddle table.
  function automatic int twiddle_q(input int k, input int n, input int frac,
                                   input bit want_sin);
    real ang;
    real x2;
    real term;
    real acc;
    real scaled;
    ang = TWO_PI * real'(k) / real'(n);
    // Fold into [-pi, pi] so the series converges quickly.
    if (ang > TWO_PI / 2.0) ang = ang - TWO_PI;
    x2 = ang * ang;
    if (want_sin) begin
      term = ang;
      acc  = ang;
      for (int i = 1; i <= TAYLOR_TERMS; i++) begin
        term = -term * x2 / real'((2 * i) * (2 * i + 1));
        acc  = acc + term;
      end
    end else begin
      term = 1.0;
      acc  = 1.0;
      for (int i = 1; i <= TAYLOR_TERMS; i++) begin
        term = -term * x2 / real'((2 * i - 1) * (2 * i));
        acc  = acc + term;
      end
    end
    scaled = acc * real'(1 << frac);
    return $rtoi((scaled >= 0.0) ? scaled + 0.5 : scaled - 0.5);
  endfunction

endpackage

// File: rtl/sdft_twiddle_rom.sv
// Combinational twiddle ROM: W_k = cos(2*pi*k/N) + j*sin(2*pi*k/N).
module sdft_twiddle_rom
  import sdft_pkg::*;
#(
  parameter int freq_bins  = 16,
  parameter int coef_width = 12,
  localparam int IDX_W     = $clog2(freq_bins)
) (
  input  logic        [IDX_W-1:0]      idx,
  output logic signed [coef_width-1:0] twd_cos,
  output logic signed [coef_width-1:0] twd_sin
);

  logic signed [coef_width-1:0] cos_tab [freq_bins];
  logic signed [coef_width-1:0] sin_tab [freq_bins];

  for (genvar g = 0; g < freq_bins; g++) begin : g_tab
    assign cos_tab[g] = coef_width'(twiddle_q(g, freq_bins, coef_width - COEF_GUARD, 1'b0));
    assign sin_tab[g] = coef_width'(twiddle_q(g, freq_bins, coef_width - COEF_GUARD, 1'b1));
  end

  assign twd_cos = cos_tab[idx];
  assign twd_sin = sin_tab[idx];

endmodule

// File: rtl/sdft_stream.sv
// Sliding DFT over the last freq_bins samples; each accepted sample updates
// every bin serially, one complex multiply-accumulate per cycle.
module sdft_stream
  import sdft_pkg::*;
#(
  parameter int data_width  = 8,
  parameter int freq_bins   = 16,
  parameter int coef_width  = 12,
  parameter int bin_width   = data_width + $clog2(freq_bins) + 1,
  localparam int ADDR_W     = $clog2(freq_bins)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [data_width-1:0] sample,
  input  logic                         start,
  input  logic                         clear,
  output logic                         ready,
  input  logic        [ADDR_W-1:0]     bin_addr,
  output logic signed [bin_width-1:0]  bin_real,
  output logic signed [bin_width-1:0]  bin_imag,
  output logic                         overflow
);

  localparam int D_W  = data_width + 1;
  localparam int A_W  = bin_width + 1;
  localparam int P_W  = bin_width + coef_width + 2;
  localparam int FRAC = coef_width - COEF_GUARD;
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(freq_bins - 1);
  localparam logic signed [P_W-1:0] SAT_MAX =
    {{(P_W - bin_width + 1){1'b0}}, {(bin_width - 1){1'b1}}};
  localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

  // MSB flags a clamp; low bits are the bin-width result.
  function automatic logic [bin_width:0] sat_bin(input logic signed [P_W-1:0] v);
    if (v > SAT_MAX) return {1'b1, SAT_MAX[bin_width-1:0]};
    if (v < SAT_MIN) return {1'b1, SAT_MIN[bin_width-1:0]};
    return {1'b0, v[bin_width-1:0]};
  endfunction

  state_t                      state_q, state_d;
  logic        [ADDR_W-1:0]    k_q, k_d;
  logic        [ADDR_W-1:0]    ptr_q, ptr_d;
  logic signed [data_width-1:0] cap_q, cap_d;
  logic signed [D_W-1:0]       d_q, d_d;
  logic                        ovf_q, ovf_d;
  logic signed [bin_width-1:0] rd_re_q, rd_im_q;

  logic signed [data_width-1:0] hist_q   [freq_bins];
  logic signed [bin_width-1:0]  bin_re_q [freq_bins];
  logic signed [bin_width-1:0]  bin_im_q [freq_bins];

  logic                         wipe, bin_we, hist_we;
  logic signed [coef_width-1:0] twd_cos, twd_sin;
  logic signed [A_W-1:0]        a_re, a_im;
  logic signed [P_W-1:0]        p_re, p_im;
  logic        [bin_width:0]    sat_re, sat_im;
  logic signed [bin_width-1:0]  new_re, new_im;
  logic                         upd_ovf;

  sdft_twiddle_rom #(
    .freq_bins (freq_bins),
    .coef_width(coef_width)
  ) u_rom (
    .idx    (k_q),
    .twd_cos(twd_cos),
    .twd_sin(twd_sin)
  );

  // Bin datapath: (X_k + d) * W_k at full precision, floor-shift, clamp.
  always_comb begin
    a_re    = A_W'(bin_re_q[k_q]) + A_W'(d_q);
    a_im    = A_W'(bin_im_q[k_q]);
    p_re    = P_W'(a_re) * P_W'(twd_cos) - P_W'(a_im) * P_W'(twd_sin);
    p_im    = P_W'(a_re) * P_W'(twd_sin) + P_W'(a_im) * P_W'(twd_cos);
    sat_re  = sat_bin(p_re >>> FRAC);
    sat_im  = sat_bin(p_im >>> FRAC);
    new_re  = sat_re[bin_width-1:0];
    new_im  = sat_im[bin_width-1:0];
    upd_ovf = sat_re[bin_width] | sat_im[bin_width];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ptr_d   = ptr_q;
    cap_d   = cap_q;
    d_d     = d_q;
    ovf_d   = ovf_q;
    ready   = 1'b0;
    wipe    = 1'b0;
    bin_we  = 1'b0;
    hist_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (clear) begin
          wipe  = 1'b1;
          ovf_d = 1'b0;
        end else if (start) begin
          cap_d   = sample;
          state_d = ST_DELTA;
        end
      end
      ST_DELTA: begin
        d_d     = D_W'(cap_q) - D_W'(hist_q[ptr_q]);
        k_d     = '0;
        state_d = ST_BINS;
      end
      ST_BINS: begin
        bin_we = 1'b1;
        ovf_d  = ovf_q | upd_ovf;
        k_d    = k_q + ADDR_W'(1);
        if (k_q == LAST_K) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        hist_we = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      ptr_q   <= '0;
      cap_q   <= '0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
      rd_re_q <= '0;
      rd_im_q <= '0;
      for (int i = 0; i < freq_bins; i++) begin
        hist_q[i]   <= '0;
        bin_re_q[i] <= '0;
        bin_im_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      cap_q   <= cap_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
      rd_re_q <= bin_re_q[bin_addr];
      rd_im_q <= bin_im_q[bin_addr];
      if (wipe) begin
        for (int i = 0; i < freq_bins; i++) begin
          hist_q[i]   <= '0;
          bin_re_q[i] <= '0;
          bin_im_q[i] <= '0;
        end
      end else begin
        if (bin_we) begin
          bin_re_q[k_q] <= new_re;
          bin_im_q[k_q] <= new_im;
        end
        if (hist_we) hist_q[ptr_q] <= cap_q;
      end
    end
  end

  assign bin_real = rd_re_q;
  assign bin_imag = rd_im_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sdft_stream.sv
// Bench: default-width and narrow-bin (10-bit) instances driven in lockstep,
// compared against a sliding-window DFT recurrence model.
module tb_sdft_stream;

  localparam int N   = 16;
  localparam int DW  = 8;
  localparam int CW  = 12;
  localparam int BWW = DW + $clog2(N) + 1;
  localparam int BWN = 10;
  localparam int FR  = CW - 2;

  logic clk = 1'b0;
  logic reset, start, clear;
  logic signed [DW-1:0] sample;
  logic [3:0] bin_addr;
  logic ready_w, ready_n, ovf_w, ovf_n;
  logic signed [BWW-1:0] re_w, im_w;
  logic signed [BWN-1:0] re_n, im_n;

  always #5 clk = ~clk;

  sdft_stream #(.data_width(DW), .freq_bins(N), .coef_width(CW)) dut_w (
    .clk(clk), .reset(reset), .sample(sample), .start(start), .clear(clear),
    .ready(ready_w), .bin_addr(bin_addr), .bin_real(re_w), .bin_imag(im_w),
    .overflow(ovf_w));

  sdft_stream #(.data_width(DW), .freq_bins(N), .coef_width(CW), .bin_width(BWN)) dut_n (
    .clk(clk), .reset(reset), .sample(sample), .start(start), .clear(clear),
    .ready(ready_n), .bin_addr(bin_addr), .bin_real(re_n), .bin_imag(im_n),
    .overflow(ovf_n));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tw_c [N];
  int tw_s [N];
  int hist [N];
  int ptr;
  int m_re [2][N];
  int m_im [2][N];
  bit m_ovf [2];
  int bw_of [2];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      hist[k] = 0;
      for (int w = 0; w < 2; w++) begin
        m_re[w][k] = 0;
        m_im[w][k] = 0;
      end
    end
    m_ovf[0] = 1'b0;
    m_ovf[1] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    ptr = 0;
  endtask

  function automatic int clamp(input longint v, input int bw, inout bit ovf);
    longint lim;
    lim = longint'(1) << (bw - 1);
    if (v > lim - 1) begin ovf = 1'b1; return int'(lim - 1); end
    if (v < -lim)    begin ovf = 1'b1; return int'(-lim); end
    return int'(v);
  endfunction

  // X_k <- sat(floor(((X_k + x_new - x_oldest) * W_k))) over a circular window.
  task automatic model_start(input int x);
    int d;
    longint a, b, pr, pi;
    d = x - hist[ptr];
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < N; k++) begin
        a  = longint'(m_re[w][k] + d);
        b  = longint'(m_im[w][k]);
        pr = (a * tw_c[k] - b * tw_s[k]) >>> FR;
        pi = (a * tw_s[k] + b * tw_c[k]) >>> FR;
        m_re[w][k] = clamp(pr, bw_of[w], m_ovf[w]);
        m_im[w][k] = clamp(pi, bw_of[w], m_ovf[w]);
      end
    end
    hist[ptr] = x;
    ptr = (ptr + 1) % N;
  endtask

  task automatic read_bin(input int k, output int rw, output int iw,
                          output int rn, output int inn);
    bin_addr = 4'(k);
    @(posedge clk); #1;
    rw = int'(re_w); iw = int'(im_w); rn = int'(re_n); inn = int'(im_n);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      bin_addr = 4'(k);
      @(posedge clk); #1;
      chk($sformatf("%s_w_re%0d", tag, k), re_w, m_re[0][k]);
      chk($sformatf("%s_w_im%0d", tag, k), im_w, m_im[0][k]);
      chk($sformatf("%s_n_re%0d", tag, k), re_n, m_re[1][k]);
      chk($sformatf("%s_n_im%0d", tag, k), im_n, m_im[1][k]);
    end
    chk({tag, "_ovf_w"}, ovf_w, m_ovf[0]);
    chk({tag, "_ovf_n"}, ovf_n, m_ovf[1]);
    chk({tag, "_ready"}, ready_w, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_clear();
    chk("clear_ready_before", ready_w, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_ready_after_w", ready_w, 1);
    chk("clear_ready_after_n", ready_n, 1);
    model_clear();
  endtask

  task automatic wait_ready();
    int waitc;
    waitc = 0;
    while (ready_w !== 1'b1 && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("ready_before_start", ready_w, 1);
  endtask

  // Counts ready-low cycles; optionally toggles start/clear/sample while busy.
  task automatic wait_busy(input bit noise, input bit hold_start, output int busy);
    busy = 0;
    while (ready_w === 1'b0 && busy < 100) begin
      busy++;
      sample = DW'($urandom);
      if (noise && busy < 10) begin
        start = 1'($urandom % 2);
        clear = 1'($urandom % 2);
      end else begin
        start = hold_start;
        clear = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_sample(input int x, input bit noise);
    int busy;
    wait_ready();
    sample = DW'(x);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_busy(noise, 1'b0, busy);
    chk("busy_cycles", busy, 18);
    chk("ready_n_after", ready_n, 1);
    model_start(x);
  endtask

  initial begin
    int rw, iw, rn, inn, busy, x, t_prev;
    real mag;
    bw_of[0] = BWW;
    bw_of[1] = BWN;
    for (int k = 0; k < N; k++) begin
      tw_c[k] = $rtoi($floor($cos(6.283185307179586 * k / N) * 1024.0 + 0.5));
      tw_s[k] = $rtoi($floor($sin(6.283185307179586 * k / N) * 1024.0 + 0.5));
    end
    reset = 1'b1; start = 1'b0; clear = 1'b0; sample = '0; bin_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_ready", ready_w, 1);
    chk("rst_ovf", ovf_w, 0);
    chk("rst_bin_real", re_w, 0);
    chk("rst_bin_imag", im_w, 0);
    check_all("reset");

    // Constant +100 fills the window: all energy in bin 0.
    for (int i = 0; i < 16; i++) run_sample(100, (i % 4) == 1);
    check_all("dc");
    read_bin(0, rw, iw, rn, inn);
    chk("dc_x0_re", rw, 1600);
    chk("dc_x0_im", iw, 0);
    for (int k = 1; k < N; k++) begin
      read_bin(k, rw, iw, rn, inn);
      chk($sformatf("dc_leak%0d", k), (rw * rw + iw * iw) <= 256, 1);
    end
    chk("dc_ovf_w", ovf_w, 0);

    // Narrow instance saturation, then clear.
    do_clear();
    check_all("clear1");
    for (int i = 0; i < 16; i++) run_sample(127, 1'b0);
    read_bin(0, rw, iw, rn, inn);
    chk("sat_x0_re_n", rn, 511);
    chk("sat_ovf_n", ovf_n, 1);
    check_all("sat");
    do_clear();
    check_all("clear2");
    chk("clear2_ovf_n", ovf_n, 0);

    // Square wave: two periods of 8 x -100 then 8 x +100.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) run_sample(-100, 1'b0);
      for (int i = 0; i < 8; i++) run_sample(100, 1'b1);
    end
    check_all("square");
    read_bin(0, rw, iw, rn, inn);
    chk("sq_x0", (rw >= -2 && rw <= 2 && iw >= -2 && iw <= 2), 1);
    read_bin(1, rw, iw, rn, inn);
    mag = $sqrt(real'(rw * rw + iw * iw));
    chk("sq_x1_mag", (mag >= 1004.5 && mag <= 1045.5), 1);
    for (int k = 2; k < N; k += 2) begin
      read_bin(k, rw, iw, rn, inn);
      chk($sformatf("sq_even%0d", k), (rw * rw + iw * iw) <= 256, 1);
    end

    // start held high: back-to-back acceptances, history wraps after 16.
    do_reset();
    start = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 20; i++) begin
      wait_ready();
      x = int'($urandom_range(0, 255)) - 128;
      sample = DW'(x);
      @(posedge clk); #1;
      if (i > 0) chk("held_period", cyc - t_prev, 19);
      t_prev = cyc;
      wait_busy(1'b0, 1'b1, busy);
      chk("held_busy", busy, 18);
      model_start(x);
    end
    start = 1'b0;
    check_all("wrap");

    // Reset in the middle of the bin sweep (k = 5).
    for (int i = 0; i < 3; i++) run_sample(int'($urandom_range(0, 255)) - 128, 1'b0);
    wait_ready();
    sample = 8'sd77;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("mid_rst_ready", ready_w, 1);
    chk("mid_rst_ovf", ovf_w, 0);
    chk("mid_rst_re", re_w, 0);
    chk("mid_rst_im", im_w, 0);
    check_all("midreset");
    run_sample(100, 1'b0);
    read_bin(0, rw, iw, rn, inn);
    chk("mid_rst_x0_re", rw, 100);
    chk("mid_rst_x0_im", iw, 0);

    // start and clear together in IDLE: clear wins, no processing.
    for (int i = 0; i < 3; i++) run_sample(int'($urandom_range(0, 255)) - 128, 1'b1);
    wait_ready();
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      chk("sc_ready", ready_w, 1);
      @(posedge clk); #1;
    end
    check_all("startclear");

    // Randomized samples with bus noise while busy.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      run_sample(int'($urandom_range(0, 255)) - 128, 1'b1);
      if (i % 20 == 19) check_all($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
